// File: rtl/sudoku_pkg.sv
// Shared constants for the Sudoku cell array: commands, sizes
// and the sequencer state encoding.
package sudoku_pkg;

  localparam int N_CELLS = 81;
  localparam int IDX_W   = 7;
  localparam int VAL_W   = 4;
  localparam int VAL_MAX = 9;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_WRITE = 4'h0;
  localparam cmd_t CMD_READ  = 4'h1;
  localparam cmd_t CMD_NOP   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_OUT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/grid_cell_sequencer_if.sv
// Host streams, control and cell bus of the grid sequencer.
// master = sequencer side, slave = host/array side.
interface grid_cell_sequencer_if
  import sudoku_pkg::*;
#(
  parameter int IDX_W = sudoku_pkg::IDX_W,
  parameter int VAL_W = sudoku_pkg::VAL_W
);

  logic             start_load;
  logic             start_read;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err_value;

  logic             in_valid;
  logic [VAL_W-1:0] in_data;
  logic             in_ready;

  logic             out_valid;
  logic [VAL_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_ready;

  logic [IDX_W-1:0] cell_sel;
  cmd_t             cell_cmd;
  logic [VAL_W-1:0] cell_wdata;
  logic             cell_wr_rdy;
  logic [VAL_W-1:0] cell_rdata;

  modport master (
    input  start_load, start_read, abort,
    input  in_valid, in_data, out_ready,
    input  cell_rdata,
    output busy, done, err_value,
    output in_ready, out_valid, out_data, out_idx,
    output cell_sel, cell_cmd, cell_wdata, cell_wr_rdy
  );

  modport slave (
    output start_load, start_read, abort,
    output in_valid, in_data, out_ready,
    output cell_rdata,
    input  busy, done, err_value,
    input  in_ready, out_valid, out_data, out_idx,
    input  cell_sel, cell_cmd, cell_wdata, cell_wr_rdy
  );

endinterface

// File: rtl/grid_cell_sequencer.sv
// Sequences the shared cell cmd/data bus: LOAD streams a puzzle
// into the cells in raster order, READBACK streams every cell out.
module grid_cell_sequencer
  import sudoku_pkg::*;
#(
  parameter int N_CELLS = sudoku_pkg::N_CELLS,
  parameter int IDX_W   = sudoku_pkg::IDX_W,
  parameter int VAL_W   = sudoku_pkg::VAL_W
) (
  input logic                   clk,
  input logic                   rst,
  grid_cell_sequencer_if.master bus
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             in_fire;
  logic             out_fire;
  logic             val_ok;

  assign last     = idx == IDX_W'(N_CELLS - 1);
  assign in_fire  = bus.in_valid && (state == ST_LOAD);
  assign out_fire = bus.out_valid && bus.out_ready
                    && (state == ST_RD_OUT);
  assign val_ok   = bus.in_data <= VAL_W'(VAL_MAX);

  assign bus.busy     = state != ST_IDLE;
  assign bus.in_ready = state == ST_LOAD;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode; abort overrides every state
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start_load)      state_nxt = ST_LOAD;
          else if (bus.start_read) state_nxt = ST_RD_ISSUE;
        end
        ST_LOAD: begin
          if (in_fire && last) state_nxt = ST_DONE;
        end
        ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
        ST_RD_WAIT:  state_nxt = ST_RD_OUT;
        ST_RD_OUT: begin
          if (out_fire) state_nxt = last ? ST_DONE : ST_RD_ISSUE;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // index counter and registered bus/stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx             <= '0;
      bus.cell_sel    <= '0;
      bus.cell_cmd    <= CMD_NOP;
      bus.cell_wdata  <= '0;
      bus.cell_wr_rdy <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_idx     <= '0;
      bus.done        <= 1'b0;
      bus.err_value   <= 1'b0;
    end else begin
      bus.cell_cmd    <= CMD_NOP;
      bus.cell_wr_rdy <= 1'b0;
      bus.done        <= 1'b0;
      if (bus.abort) begin
        idx           <= '0;
        bus.out_valid <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (bus.start_load) begin
              idx           <= '0;
              bus.err_value <= 1'b0;
            end else if (bus.start_read) begin
              idx          <= '0;
              bus.cell_sel <= '0;
              bus.cell_cmd <= CMD_READ;
            end
          end
          ST_LOAD: begin
            if (in_fire) begin
              bus.cell_sel    <= idx;
              bus.cell_cmd    <= CMD_WRITE;
              bus.cell_wr_rdy <= 1'b1;
              bus.cell_wdata  <= val_ok ? bus.in_data : '0;
              if (!val_ok) bus.err_value <= 1'b1;
              if (!last)   idx <= idx + 1'b1;
            end
          end
          ST_RD_ISSUE: begin
          end
          ST_RD_WAIT: begin
            bus.out_data  <= bus.cell_rdata;
            bus.out_idx   <= idx;
            bus.out_valid <= 1'b1;
          end
          ST_RD_OUT: begin
            if (out_fire) begin
              bus.out_valid <= 1'b0;
              if (!last) begin
                idx          <= idx + 1'b1;
                bus.cell_sel <= idx + 1'b1;
                bus.cell_cmd <= CMD_READ;
              end
            end
          end
          ST_DONE: begin
            bus.done <= 1'b1;
            idx      <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
